// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner and its per-button channels.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int BTN_CNT_W = 8;

    function automatic bit in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, tick-sampled debounce FSM, registered level/press/release.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeating press pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int STABLE_TICKS  = 4,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam logic [BTN_CNT_W-1:0] STABLE_LIM = BTN_CNT_W'(STABLE_TICKS);

    logic                 sync1_reg;
    logic                 sync2_reg;
    btn_state_t           state_reg;
    logic [BTN_CNT_W-1:0] cnt_reg;
    logic [BTN_CNT_W-1:0] cnt_next;
    logic                 level_reg;
    logic                 press_reg;
    logic                 release_reg;

    assign cnt_next = cnt_reg + BTN_CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [BTN_CNT_W-1:0] RPT_AT = BTN_CNT_W'(REPEAT_DELAY);
    // Modulo-256 reload: counting back up to RPT_AT always takes exactly REPEAT_PERIOD ticks.
    localparam logic [BTN_CNT_W-1:0] RPT_RELOAD = BTN_CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [BTN_CNT_W-1:0] rpt_reg;
    logic [BTN_CNT_W-1:0] rpt_next;

    assign rpt_next = rpt_reg + BTN_CNT_W'(1);
`else
    // Repeat timing is only meaningful with auto-repeat compiled in.
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_reg     <= '0;
`endif
        end else begin
            sync1_reg   <= raw;
            sync2_reg   <= sync1_reg;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            if (tick) begin
                case (state_reg)
                    IDLE: begin
                        if (sync2_reg) begin
                            if (STABLE_TICKS == 1) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
                                level_reg <= 1'b1;
                                press_reg <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                                rpt_reg   <= '0;
`endif
                            end else begin
                                state_reg <= PRESS_PEND;
                                cnt_reg   <= BTN_CNT_W'(1);
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!sync2_reg) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end else if (cnt_next == STABLE_LIM) begin
                            state_reg <= HELD;
                            cnt_reg   <= '0;
                            level_reg <= 1'b1;
                            press_reg <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt_reg   <= '0;
`endif
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                    HELD: begin
                        if (!sync2_reg) begin
                            if (STABLE_TICKS == 1) begin
                                state_reg   <= IDLE;
                                cnt_reg     <= '0;
                                level_reg   <= 1'b0;
                                release_reg <= 1'b1;
                            end else begin
                                state_reg <= RELEASE_PEND;
                                cnt_reg   <= BTN_CNT_W'(1);
                            end
                        end else begin
`ifdef BTN_AUTOREPEAT_EN
                            if (rpt_next == RPT_AT) begin
                                press_reg <= 1'b1;
                                rpt_reg   <= RPT_RELOAD;
                            end else begin
                                rpt_reg <= rpt_next;
                            end
`endif
                        end
                    end
                    RELEASE_PEND: begin
                        // A bounce back to 1 resumes HELD with the repeat counter untouched.
                        if (sync2_reg) begin
                            state_reg <= HELD;
                            cnt_reg   <= '0;
                        end else if (cnt_next == STABLE_LIM) begin
                            state_reg   <= IDLE;
                            cnt_reg     <= '0;
                            level_reg   <= 1'b0;
                            release_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign level         = level_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: derives the shared sample tick from debounce_clk and fans out
// one btn_channel per button. Optional auto-repeat is enabled with BTN_AUTOREPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_TICKS  = 4,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debounce_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam bit PARAMS_OK = in_range(N_BTN, 1, 8)
                            && in_range(STABLE_TICKS, 1, 255)
                            && in_range(REPEAT_DELAY, 1, 255)
                            && in_range(REPEAT_PERIOD, 1, 255);

    logic dclk_q_reg;
    logic tick;

    // Resetting to 1 means a strobe already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_q_reg <= 1'b1;
        end else begin
            dclk_q_reg <= debounce_clk;
        end
    end

    assign tick = debounce_clk & ~dclk_q_reg;

    generate
        if (PARAMS_OK) begin : g_ok
            for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
                btn_channel #(
                    .STABLE_TICKS  (STABLE_TICKS),
                    .REPEAT_DELAY  (REPEAT_DELAY),
                    .REPEAT_PERIOD (REPEAT_PERIOD)
                ) u_channel (
                    .clk           (clk),
                    .rst           (rst),
                    .tick          (tick),
                    .raw           (btn_raw[gi]),
                    .level         (btn_level[gi]),
                    .press         (btn_press[gi]),
                    .release_pulse (btn_release[gi])
                );
            end
        end else begin : g_bad_params
            // Out-of-range configuration: outputs stay quiet rather than misbehave.
            assign btn_level   = '0;
            assign btn_press   = '0;
            assign btn_release = '0;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_button_conditioner;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         debounce_clk = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    button_conditioner #(
        .N_BTN         (N),
        .STABLE_TICKS  (4),
        .REPEAT_DELAY  (3),
        .REPEAT_PERIOD (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .debounce_clk (debounce_clk),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
        int           tick;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    int           tick_num = 0;
    int           phase = 0;
    logic [N-1:0] lvl_model = '0;
    logic         rst_seen = 1'b0;

    task automatic push(input string name, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input int t);
        exp_t e;
        e.name = name; e.press = p; e.rel = r; e.level = l; e.tick = t;
        exp_q.push_back(e);
    endtask

    // One clk; debounce_clk is high for 4 clk out of 8, tick_num counts its rising edges.
    task automatic clk_step();
        @(posedge clk);
        #1;
        phase = phase + 1;
        debounce_clk = ((phase % 8) >= 4);
        if ((phase % 8) == 4) tick_num = tick_num + 1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) clk_step();
    endtask

    // Returns just after debounce_clk rises: the next posedge is tick number tick_num.
    task automatic to_tick();
        do clk_step(); while ((phase % 8) != 4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) to_tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            compared++;
            if ({btn_press, btn_release, btn_level} != '0) begin
                mismatched++;
                $display("FAIL reset_clear: press=%b release=%b level=%b, required all 0",
                         btn_press, btn_release, btn_level);
            end
            lvl_model = '0;
        end else if ((btn_press | btn_release) != '0) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse: press=%b release=%b level=%b tick=%0d, required none",
                         btn_press, btn_release, btn_level, tick_num);
            end else begin
                e = exp_q.pop_front();
                if (btn_press !== e.press || btn_release !== e.rel ||
                    btn_level !== e.level || tick_num != e.tick) begin
                    mismatched++;
                    $display("FAIL %s: press=%b release=%b level=%b tick=%0d, required press=%b release=%b level=%b tick=%0d",
                             e.name, btn_press, btn_release, btn_level, tick_num,
                             e.press, e.rel, e.level, e.tick);
                end else begin
                    $display("ok   %s: press=%b release=%b level=%b tick=%0d",
                             e.name, btn_press, btn_release, btn_level, tick_num);
                end
                lvl_model = e.level;
            end
        end else begin
            compared++;
            if (btn_level !== lvl_model) begin
                mismatched++;
                $display("FAIL level_hold: level=%b tick=%0d, required %b",
                         btn_level, tick_num, lvl_model);
            end
        end
        rst_seen = rst;
    end

    initial begin
        int t0;
        steps(6);
        rst = 1'b0;
        ticks(2);

        // Clean press and release on button 0.
        to_tick(); t0 = tick_num;
        btn_raw[0] = 1'b1;
        push("press0", 4'b0001, 4'b0000, 4'b0001, t0 + 4);
        ticks(6); t0 = tick_num;
        btn_raw[0] = 1'b0;
        push("release0", 4'b0000, 4'b0001, 4'b0000, t0 + 4);
        ticks(6);

        // Glitch on button 1 seen by two ticks only: no pulse, level unchanged.
        to_tick();
        btn_raw[1] = 1'b1;
        ticks(2);
        btn_raw[1] = 1'b0;
        ticks(6);

        // Button 2: press, bouncy release, then settle low.
        to_tick(); t0 = tick_num;
        btn_raw[2] = 1'b1;
        push("press2", 4'b0100, 4'b0000, 4'b0100, t0 + 4);
        ticks(6);
        for (int s = 0; s < 8; s++) begin
            btn_raw[2] = s[0];
            steps(10);
        end
        btn_raw[2] = 1'b1;
        steps(16);
        to_tick(); t0 = tick_num;
        btn_raw[2] = 1'b0;
        push("release2_bounce", 4'b0000, 4'b0100, 4'b0000, t0 + 4);
        ticks(6);

        // Button 3: held, release pending with 3 counts, reset lands on the accepting tick.
        to_tick(); t0 = tick_num;
        btn_raw[3] = 1'b1;
        push("press3", 4'b1000, 4'b0000, 4'b1000, t0 + 4);
        ticks(6);
        btn_raw[3] = 1'b0;
        ticks(4);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        ticks(6);

        // Reset while button 1 is pending: its count restarts afterwards.
        to_tick(); t0 = tick_num;
        btn_raw[1] = 1'b1;
        ticks(2);
        steps(2);
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        push("press1_after_rst", 4'b0010, 4'b0000, 4'b0010, t0 + 6);
        ticks(6); t0 = tick_num;
        btn_raw[1] = 1'b0;
        push("release1", 4'b0000, 4'b0010, 4'b0000, t0 + 4);
        ticks(6);

        // All buttons together.
        to_tick(); t0 = tick_num;
        btn_raw = 4'b1111;
        push("press_all", 4'b1111, 4'b0000, 4'b1111, t0 + 4);
        ticks(6); t0 = tick_num;
        btn_raw = 4'b0000;
        push("release_all", 4'b0000, 4'b1111, 4'b0000, t0 + 4);
        ticks(6);

`ifdef BTN_AUTOREPEAT_EN
        // Auto-repeat on button 0: acceptance, +3 ticks, then every 2 ticks.
        to_tick(); t0 = tick_num;
        btn_raw[0] = 1'b1;
        push("rpt_accept", 4'b0001, 4'b0000, 4'b0001, t0 + 4);
        push("rpt_first", 4'b0001, 4'b0000, 4'b0001, t0 + 7);
        push("rpt_second", 4'b0001, 4'b0000, 4'b0001, t0 + 9);
        push("rpt_third", 4'b0001, 4'b0000, 4'b0001, t0 + 11);
        push("rpt_release", 4'b0000, 4'b0001, 4'b0000, t0 + 15);
        ticks(11);
        btn_raw[0] = 1'b0;
        ticks(8);
`endif

        ticks(2);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_events: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
